// File: rtl/fifo_axil_arbiter.sv
// fifo_axil_arbiter: round-robin arbiter sharing one AXI4-Lite master port between two requesters
module fifo_axil_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [1:0]                req,
  input  logic [1:0]                we,
  input  logic [2*C_ADDR_WIDTH-1:0] addr,
  input  logic [2*C_DATA_WIDTH-1:0] wdata,
  output logic [1:0]                ack,
  output logic [C_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                resp,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;
  state_t state, next;
  logic last, gnt, pick, aw_done, w_done, aw_fin, w_fin, b_hs, r_hs;
  logic [C_ADDR_WIDTH-1:0] a_q;
  logic [C_DATA_WIDTH-1:0] d_q;
  assign M_AXI_AWADDR  = a_q;
  assign M_AXI_ARADDR  = a_q;
  assign M_AXI_WDATA   = d_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = (state == WRITE) & ~aw_done;
  assign M_AXI_WVALID  = (state == WRITE) & ~w_done;
  assign M_AXI_BREADY  = state == WRESP;
  assign M_AXI_ARVALID = state == READ;
  assign M_AXI_RREADY  = state == RDATA;
  // round-robin pick (last winner loses ties) and next-state decode
  always_comb begin
    pick = req[1] & (~req[0] | ~last);
    aw_fin = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
    w_fin = w_done | (M_AXI_WVALID & M_AXI_WREADY);
    b_hs = M_AXI_BREADY & M_AXI_BVALID;
    r_hs = M_AXI_RREADY & M_AXI_RVALID;
    next = state;
    case (state)
      IDLE:    next = ~|req ? IDLE : (we[pick] ? WRITE : READ);
      WRITE:   next = (aw_fin & w_fin) ? WRESP : WRITE;
      WRESP:   next = M_AXI_BVALID ? IDLE : WRESP;
      READ:    next = M_AXI_ARREADY ? RDATA : READ;
      RDATA:   next = M_AXI_RVALID ? IDLE : RDATA;
      default: next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else state <= next;
  end
  // grant capture, AW/W completion tracking and response/ack registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last <= 1'b1;
      gnt <= 1'b0;
      a_q <= '0;
      d_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      ack <= 2'b00;
      resp <= 2'b00;
      rdata <= '0;
    end else begin
      aw_done <= (state != IDLE) & aw_fin;
      w_done <= (state != IDLE) & w_fin;
      ack <= (b_hs | r_hs) ? {gnt, ~gnt} : 2'b00;
      if (b_hs) resp <= M_AXI_BRESP;
      if (r_hs) resp <= M_AXI_RRESP;
      if (r_hs) rdata <= M_AXI_RDATA;
      if (state == IDLE && |req) begin
        gnt <= pick;
        last <= pick;
        a_q <= pick ? addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH] : addr[C_ADDR_WIDTH-1:0];
        d_q <= pick ? wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH] : wdata[C_DATA_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_fifo_axil_arbiter.sv
// tb_fifo_axil_arbiter: scoreboard bench with an AXI4-Lite slave model for fifo_axil_arbiter
module tb_fifo_axil_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;
  typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} axi_t;
  typedef struct packed {logic [1:0] ack; logic [1:0] resp; logic [DW-1:0] rdata; logic rd;} ack_t;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0] ack, resp;
  logic [DW-1:0] rdata;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata_m;
  logic [DW/8-1:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp_s = '0, rresp_s = '0;
  logic [DW-1:0] rdata_s = '0;
  axi_t axq[$];
  ack_t ackq[$];
  ack_t mon_e;
  int pass_cnt = 0, total_cnt = 0;
  int aw_delay = 0, b_lat = 2, r_lat = 2;
  int aw_cnt = 0, b_cnt = 0, r_cnt = 0, aw_hi = 0, w_hi = 0;
  bit aw_got = 0, w_got = 0, b_hs = 0, r_hs = 0;
  bit bready_early = 0, overlap = 0, double_ack = 0;
  logic [1:0] prev_ack = '0;

  fifo_axil_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .resp(resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata_m), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp_s), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata_s), .M_AXI_RRESP(rresp_s), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s", name);
  endtask

  // slave model: decides ready/valid at the falling edge for the next rising edge
  always @(negedge ACLK) begin
    if (ARESET) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_cnt = 0; b_cnt = 0; r_cnt = 0; aw_got = 0; w_got = 0; b_hs = 0; r_hs = 0;
    end else begin
      if (b_hs) begin bvalid = 0; b_hs = 0; end
      if (r_hs) begin rvalid = 0; r_hs = 0; end
      if (b_cnt > 0) begin b_cnt--; if (b_cnt == 0) bvalid = 1; end
      if (r_cnt > 0) begin r_cnt--; if (r_cnt == 0) rvalid = 1; end
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if ((awvalid | wvalid) & arvalid) overlap = 1;
      if (bready & (awvalid | wvalid)) bready_early = 1;
      awready = 0;
      if (awvalid && !aw_got) begin
        if (aw_cnt == aw_delay) begin
          awready = 1; aw_got = 1; aw_cnt = 0;
          if (axq.size() == 0) fail("aw_unexpected");
          else begin chk("aw_is_write", axq[0].w, 1); chk("awaddr", awaddr, axq[0].a); end
        end else aw_cnt++;
      end
      wready = 0;
      if (wvalid && !w_got) begin
        wready = 1; w_got = 1;
        if (axq.size() == 0) fail("w_unexpected");
        else begin chk("wdata", wdata_m, axq[0].d); chk("wstrb", wstrb, 4'hF); end
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_cnt = b_lat;
        if (axq.size() > 0) void'(axq.pop_front());
      end
      arready = 0;
      if (arvalid) begin
        arready = 1; r_cnt = r_lat;
        if (axq.size() == 0) fail("ar_unexpected");
        else begin chk("ar_is_read", axq[0].w, 0); chk("araddr", araddr, axq[0].a); void'(axq.pop_front()); end
      end
      if (bvalid && bready) b_hs = 1;
      if (rvalid && rready) r_hs = 1;
    end
  end

  // completion monitor: every ack pops the oldest expected response
  always @(negedge ACLK) begin
    if (!ARESET && ack != 2'b00) begin
      if (ackq.size() == 0) fail("unexpected_ack");
      else begin
        mon_e = ackq.pop_front();
        chk("ack", ack, mon_e.ack);
        chk("resp", resp, mon_e.resp);
        if (mon_e.rd) chk("rdata", rdata, mon_e.rdata);
      end
    end
    if (ack != 2'b00 && prev_ack != 2'b00) double_ack = 1;
    prev_ack = ack;
  end

  task automatic do_txn(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] er, input logic [DW-1:0] erd, output int cyc);
    axq.push_back('{w: w, a: a, d: w ? d : '0});
    ackq.push_back('{ack: (i == 0) ? 2'b01 : 2'b10, resp: er, rdata: erd, rd: !w});
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    cyc = 0;
    do begin @(negedge ACLK); cyc++; end while (!ack[i] && cyc < 50);
    if (!ack[i]) fail("txn_timeout");
    req[i] = 1'b0;
  endtask

  initial begin
    int cyc, n, a0, w0;
    repeat (3) @(negedge ACLK);
    chk("rst_ack", ack, 0);
    chk("rst_valid_ready", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_resp_rdata", {resp, rdata}, 0);
    chk("rst_addr_data", {awaddr, araddr, wdata_m}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    do_txn(0, 1, 4'h4, 32'h000000A5, 2'b00, '0, cyc);
    chk("wr_latency", cyc, 4);
    rdata_s = 32'h12345678;
    do_txn(1, 0, 4'h8, '0, 2'b00, 32'h12345678, cyc);
    chk("rd_latency", cyc, 4);
    rdata_s = 32'h0BADBEEF;
    we = 2'b01;
    addr = {4'hC, 4'h0};
    wdata = {32'h0, 32'h00000011};
    for (int k = 0; k < 2; k++) begin
      axq.push_back('{w: 1'b1, a: 4'h0, d: 32'h11});
      axq.push_back('{w: 1'b0, a: 4'hC, d: '0});
      ackq.push_back('{ack: 2'b01, resp: 2'b00, rdata: '0, rd: 1'b0});
      ackq.push_back('{ack: 2'b10, resp: 2'b00, rdata: 32'h0BADBEEF, rd: 1'b1});
    end
    req = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 200) begin
      @(negedge ACLK); cyc++;
      if (ack != 2'b00) n++;
    end
    req = 2'b00;
    chk("rr_ack_count", n, 4);
    @(negedge ACLK);
    aw_delay = 3;
    a0 = aw_hi; w0 = w_hi;
    do_txn(0, 1, 4'hC, 32'h5A5A5A5A, 2'b00, '0, cyc);
    aw_delay = 0;
    chk("awvalid_cycles", aw_hi - a0, 4);
    chk("wvalid_cycles", w_hi - w0, 1);
    chk("slow_aw_latency", cyc, 7);
    bresp_s = 2'b10;
    do_txn(1, 1, 4'h8, 32'hDEAD0001, 2'b10, '0, cyc);
    bresp_s = 2'b00;
    rdata_s = 32'hCAFEF00D;
    do_txn(0, 0, 4'h4, '0, 2'b00, 32'hCAFEF00D, cyc);
    chk("after_slverr_latency", cyc, 4);
    rresp_s = 2'b11;
    rdata_s = 32'h600DF00D;
    do_txn(1, 0, 4'h0, '0, 2'b11, 32'h600DF00D, cyc);
    rresp_s = 2'b00;
    r_lat = 30;
    axq.push_back('{w: 1'b0, a: 4'h8, d: '0});
    we[0] = 1'b0;
    addr[AW-1:0] = 4'h8;
    req[0] = 1'b1;
    cyc = 0;
    while (!rready && cyc < 20) begin @(negedge ACLK); cyc++; end
    chk("reached_rdata", rready, 1);
    ARESET = 1'b1;
    #1;
    chk("abort_ack", ack, 0);
    chk("abort_valid_ready", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("abort_resp_rdata", {resp, rdata}, 0);
    chk("abort_addr_data", {awaddr, araddr, wdata_m}, 0);
    req = 2'b00;
    r_lat = 2;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("abort_no_ack", ack, 0);
    we = 2'b01;
    addr = {4'h4, 4'hC};
    wdata = {32'h0, 32'h00000077};
    axq.push_back('{w: 1'b1, a: 4'hC, d: 32'h77});
    ackq.push_back('{ack: 2'b01, resp: 2'b00, rdata: '0, rd: 1'b0});
    req = 2'b11;
    cyc = 0;
    do begin @(negedge ACLK); cyc++; end while (ack == 2'b00 && cyc < 50);
    req = 2'b00;
    chk("post_reset_first_grant", ack, 2'b01);
    repeat (3) @(negedge ACLK);
    chk("no_overlap_valids", overlap, 0);
    chk("no_early_bready", bready_early, 0);
    chk("ack_single_cycle", double_ack, 0);
    chk("axi_queue_drained", axq.size(), 0);
    chk("ack_queue_drained", ackq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
